clz_iter_unit: RTL and testbench
================================

Name: clz_iter_unit

Overview:
- Multi-cycle leading-count unit for the pipelined CPU's execute stage. Generalises the single-cycle 32-bit CLZ path.
- Parametrised operand width and chunk size; adds a count-leading-ones (CLO) mode and a start/busy/done handshake.
- Scans the operand CHUNK bits per cycle, MSB first, and stops early at the first chunk with a set bit.
- The pipeline controller stalls on busy and captures result on done.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of CHUNK.
- CHUNK, 8, bits examined per SCAN cycle. Must be ≥1 and a power of two.
- CW, $clog2(WIDTH+1), result width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only when busy=0
- mode  in  1  0 = CLZ, 1 = CLO; sampled with start
- operand  in  WIDTH  value to count; sampled with start
- busy  out  1  high while scanning
- done  out  1  one-cycle pulse: result valid
- result  out  CW  leading-zero/one count, 0..WIDTH
- all_flag  out  1  operand was all zeros (CLZ) or all ones (CLO)

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - busy=0, done=0, result=0, all_flag=0, internal shift register and count cleared.
  - Reset has priority over all other inputs, including mid-SCAN; the in-flight operation is discarded and no done is issued.
- States: IDLE, SCAN, DONE. busy = (state==SCAN). done = (state==DONE).
- IDLE or DONE with start=1:
  - Latch sreg = mode ? ~operand : operand.
  - Clear count; go to SCAN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE. result and all_flag hold.
- SCAN, each cycle: examine the top CHUNK bits of sreg.
  - Any bit set: count += leading zeros within the chunk (0..CHUNK-1). result <= count, all_flag <= 0, go to DONE.
  - Else, last chunk (WIDTH/CHUNK chunks examined): result <= WIDTH, all_flag <= 1, go to DONE.
  - Else: count += CHUNK, sreg <<= CHUNK, stay in SCAN.
- start while busy=1 is ignored. The operand is not re-sampled.
- Latency:
  - start sampled at edge 0 → k SCAN cycles (k = index of the first non-empty chunk + 1, 1 ≤ k ≤ WIDTH/CHUNK) → done high in cycle k+1.
  - Minimum 2 cycles; maximum WIDTH/CHUNK+1 cycles.
- result and all_flag change only on the SCAN→DONE transition or on reset. They stay stable between done pulses.
- Back-to-back: start asserted during the DONE cycle is accepted. done pulses once per accepted start; it is never held high for two consecutive cycles from a single op.
- Arithmetic: count is CW bits wide and never exceeds WIDTH, so no wrap. Per-chunk leading-zero detection is combinational priority logic over CHUNK bits.
- An operand or mode change after start is accepted does not affect the in-flight op.
- Elaboration: WIDTH % CHUNK != 0 is a fatal elaboration error.

Test Plan:
- WIDTH=32, CHUNK=8: CLZ of 0x8000_0000 → done in cycle 2 after start; result=0, all_flag=0; busy high for exactly 1 cycle.
- CLZ of 0x0000_0001 → 4 SCAN cycles, done in cycle 5; result=31, all_flag=0.
- CLZ of 0x0000_0000 → done in cycle 5; result=32, all_flag=1. CLO of 0xFFFF_FFFF → result=32, all_flag=1.
- CLO of 0xFFFF_0F00 → 3 SCAN cycles; result=16. Then start asserted in the DONE cycle with CLZ of 0x0040_0000 → accepted, result=9, two distinct done pulses.
- Start with 0x0000_0001; pulse start with 0x8000_0000 during SCAN → ignored, result=31. Separately, rst in the 2nd SCAN cycle → next cycle busy=0, done=0, result=0; no done pulse follows.
- WIDTH=64, CHUNK=16: CLZ of 0x0000_0000_0010_0000 → 3 SCAN cycles; result=43.

Source files
------------

// File: rtl/clz_iter_unit.sv
// Multi-cycle count-leading-zeros/ones unit: scans the operand CHUNK bits per
// cycle from the MSB and stops at the first chunk holding a set bit.
module clz_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    result,
  output logic             all_flag
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    count;
  logic [CHUNK-1:0] top_chunk;
  logic [CW-1:0]    chunk_lz;
  logic             any_set;
  logic             last_chunk;

  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $fatal(1, "clz_iter_unit: WIDTH must be a multiple of CHUNK");
  end
  if (CHUNK < 1 || (CHUNK & (CHUNK - 1)) != 0) begin : g_bad_chunk
    $fatal(1, "clz_iter_unit: CHUNK must be a power of two");
  end

  // CLO is folded into CLZ by inverting the operand at capture time.
  assign top_chunk  = sreg[WIDTH-1 -: CHUNK];
  assign any_set    = |top_chunk;
  assign last_chunk = (count == CW'(WIDTH - CHUNK));

  assign busy = (state == SCAN);
  assign done = (state == DONE);

  always_comb begin
    // NOTE: default first so every path assigns chunk_lz and no latch is inferred.
    chunk_lz = '0;
    // Ascending scan: the highest set bit is written last and wins.
    for (int i = 0; i < CHUNK; i++) begin
      if (top_chunk[i]) chunk_lz = CW'(CHUNK - 1 - i);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (any_set || last_chunk) state_nxt = DONE;
      DONE:    state_nxt = start ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      count    <= '0;
      result   <= '0;
      all_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            sreg  <= mode ? ~operand : operand;
            count <= '0;
          end
        end
        SCAN: begin
          if (any_set) begin
            result   <= count + chunk_lz;
            all_flag <= 1'b0;
          end else if (last_chunk) begin
            result   <= CW'(WIDTH);
            all_flag <= 1'b1;
          end else begin
            count <= count + CW'(CHUNK);
            sreg  <= sreg << CHUNK;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clz_iter_unit.sv
// Self-checking bench for clz_iter_unit (32/8 and 64/16 instances) against a
// bit-counting reference model.
module tb_clz_iter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mode;
  logic [31:0] operand;
  logic        busy, done, all_flag;
  logic [5:0]  result;

  logic        start64, mode64;
  logic [63:0] operand64;
  logic        busy64, done64, all_flag64;
  logic [6:0]  result64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clz_iter_unit dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .operand(operand),
    .busy(busy), .done(done), .result(result), .all_flag(all_flag)
  );

  clz_iter_unit #(.WIDTH(64), .CHUNK(16)) dut64 (
    .clk(clk), .rst(rst), .start(start64), .mode(mode64), .operand(operand64),
    .busy(busy64), .done(done64), .result(result64), .all_flag(all_flag64)
  );

  // Number of leading bits equal to m in the low w bits of v.
  function automatic int lead_ref(input logic [63:0] v, input int w, input bit m);
    int n;
    n = 0;
    for (int i = w - 1; i >= 0; i--) begin
      if (v[i] != m) return n;
      n++;
    end
    return n;
  endfunction

  function automatic int scans_ref(input int n, input int w, input int c);
    return (n == w) ? w / c : n / c + 1;
  endfunction

  task automatic start_op(input bit m, input logic [31:0] op);
    start   = 1'b1;
    mode    = m;
    operand = op;
    @(posedge clk); #1;
    start   = 1'b0;
    mode    = ~m;
    operand = $urandom;
  endtask

  // Called in cycle cyc0 after the accepting edge; runs until done or timeout.
  task automatic wait_done(input string name, input bit m, input logic [31:0] op,
                           input int cyc0);
    int n, k, cyc, scans;
    n     = lead_ref({32'b0, op}, 32, m);
    k     = scans_ref(n, 32, 8);
    cyc   = cyc0;
    scans = cyc0 - 1;
    while (!done && cyc <= 12) begin
      if (busy) scans++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, cyc);
      return;
    end
    checks++;
    if (cyc != k + 1) begin
      errors++;
      $display("FAIL %s latency: done in cycle %0d, required %0d", name, cyc, k + 1);
    end
    checks++;
    if (scans != k) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, required %0d", name, scans, k);
    end
    checks++;
    if (result !== 6'(n) || all_flag !== (n == 32) || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s result: result=%0d all=%b busy=%b, required %0d %b 0",
               name, result, all_flag, busy, n, n == 32);
    end
  endtask

  // One idle cycle after done: pulse must drop and outputs must hold.
  task automatic check_idle_after(input string name, input logic [5:0] exp_r,
                                  input logic exp_a);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp_r || all_flag !== exp_a) begin
      errors++;
      $display("FAIL %s hold: done=%b busy=%b result=%0d all=%b, required 0 0 %0d %b",
               name, done, busy, result, all_flag, exp_r, exp_a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 6'd0 || all_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b result=%0d all=%b, required 0 0 0 0",
               busy, done, result, all_flag);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ops [4];
    bit          ms  [4];
    int          n;
    ops = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
    ms  = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      start_op(ms[i], ops[i]);
      wait_done($sformatf("directed%0d", i), ms[i], ops[i], 1);
      n = lead_ref({32'b0, ops[i]}, 32, ms[i]);
      check_idle_after($sformatf("directed%0d", i), 6'(n), n == 32);
    end
  endtask

  task automatic test_back_to_back();
    start_op(1'b1, 32'hFFFF_0F00);
    wait_done("b2b_first", 1'b1, 32'hFFFF_0F00, 1);
    start_op(1'b0, 32'h0040_0000);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || result !== 6'd16) begin
      errors++;
      $display("FAIL b2b_accept: done=%b busy=%b result=%0d, required 0 1 16",
               done, busy, result);
    end
    wait_done("b2b_second", 1'b0, 32'h0040_0000, 1);
    check_idle_after("b2b_second", 6'd9, 1'b0);
  endtask

  task automatic test_ignored_start();
    start_op(1'b0, 32'h0000_0001);
    start   = 1'b1;
    mode    = 1'b0;
    operand = 32'h8000_0000;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignored_start", 1'b0, 32'h0000_0001, 2);
    check_idle_after("ignored_start", 6'd31, 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    int pulses;
    start_op(1'b0, 32'h0000_0001);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 6'd0 || all_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_scan: busy=%b done=%b result=%0d all=%b, required 0 0 0 0",
               busy, done, result, all_flag);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_no_done: active cycles=%0d, required 0", pulses);
    end
  endtask

  task automatic test_random();
    logic [31:0] op;
    bit          m;
    int          n;
    for (int i = 0; i < 40; i++) begin
      m  = 1'($urandom_range(0, 1));
      op = $urandom;
      op = op >> $urandom_range(0, 32);
      if (m) op = ~op;
      start_op(m, op);
      wait_done($sformatf("random%0d", i), m, op, 1);
      if ($urandom_range(0, 1) == 0) begin
        n = lead_ref({32'b0, op}, 32, m);
        check_idle_after($sformatf("random%0d", i), 6'(n), n == 32);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run64(input string name, input bit m, input logic [63:0] op);
    int n, k, cyc;
    n         = lead_ref(op, 64, m);
    k         = scans_ref(n, 64, 16);
    start64   = 1'b1;
    mode64    = m;
    operand64 = op;
    @(posedge clk); #1;
    start64   = 1'b0;
    operand64 = {$urandom, $urandom};
    cyc = 1;
    while (!done64 && cyc <= 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (done64 !== 1'b1 || cyc != k + 1 || result64 !== 7'(n) || all_flag64 !== (n == 64)) begin
      errors++;
      $display("FAIL %s: done=%b cycle=%0d result=%0d all=%b, required 1 %0d %0d %b",
               name, done64, cyc, result64, all_flag64, k + 1, n, n == 64);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wide64();
    logic [63:0] op;
    run64("wide_clz43", 1'b0, 64'h0000_0000_0010_0000);
    run64("wide_zero", 1'b0, 64'h0);
    run64("wide_clo_all", 1'b1, {64{1'b1}});
    for (int i = 0; i < 6; i++) begin
      op = {$urandom, $urandom};
      op = op >> $urandom_range(0, 63);
      run64($sformatf("wide_random%0d", i), 1'($urandom_range(0, 1)), op);
    end
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    operand   = '0;
    start64   = 1'b0;
    mode64    = 1'b0;
    operand64 = '0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid_scan();
    test_random();
    test_wide64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
